// File: rtl/frame_store_pkg.sv
// rtl/frame_store_pkg.sv - shared types and constants for the frame store responder
//
// Contents:
//   fsr_state_e      : transfer sequencer states (IDLE, LO, HI, ACK)
//   SCREEN_W/H       : visible raster size in pixels
//   FRAME_WORDS      : 32-bit words occupied by one frame (4 pixels per word)
//   FRAME_LIMIT      : FRAME_WORDS sized to the drawing-engine word address
//   HALF_LO/HALF_HI  : halfword select bit appended to the word address

package frame_store_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        ACK  = 2'd3
    } fsr_state_e;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int PIX_PER_WORD = 4;
    localparam int FRAME_WORDS  = SCREEN_W * SCREEN_H / PIX_PER_WORD;

    localparam logic [17:0] FRAME_LIMIT = 18'(FRAME_WORDS);

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Words at or above the frame size have no backing SRAM.
    function automatic logic in_frame(input logic [17:0] word_addr);
        return word_addr < FRAME_LIMIT;
    endfunction

endpackage

// File: rtl/fsr_wait_ctr.sv
// rtl/fsr_wait_ctr.sv - loadable down-counter that stretches an SRAM halfword access
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : number of extra cycles to hold the current half
//   done       : count has reached zero, the current cycle is the last of the half

module fsr_wait_ctr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/frame_store_responder.sv
// rtl/frame_store_responder.sv - 32-bit drawing-engine port onto a 16-bit frame store SRAM
//
// Each accepted word request becomes up to two halfword SRAM accesses (LO then HI),
// followed by a single-cycle de_ack. Fully masked write halves are skipped; reads
// always fetch both halves. Words beyond the frame are acknowledged without access.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   de_req/de_ack              : level request, one-cycle completion pulse
//   de_addr/de_nbyte/de_rnw    : word address, active-low byte enables, 1 = read
//   de_w_data/de_r_data        : write data in, read data out (valid with de_ack)
//   sram_cs/sram_we/sram_be    : SRAM strobes, active-high byte lanes
//   sram_addr                  : halfword address {word address, half}
//   sram_wdata/sram_rdata      : SRAM halfword data
//
// Build option: define FSR_WAITSTATE_EN to hold each half for 1 + WAIT_STATES
// cycles; otherwise WAIT_STATES has no effect and every half is one cycle.

module frame_store_responder
    import frame_store_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_req,
    output logic        de_ack,
    input  logic [17:0] de_addr,
    input  logic [3:0]  de_nbyte,
    input  logic        de_rnw,
    input  logic [31:0] de_w_data,
    output logic [31:0] de_r_data,
    output logic        sram_cs,
    output logic        sram_we,
    output logic [1:0]  sram_be,
    output logic [18:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata
);

    if (WAIT_STATES > 255) begin : g_ws_range
        $error("WAIT_STATES must not exceed 255");
    end

    fsr_state_e  state_q,      state_d;
    logic [17:0] addr_q,       addr_d;
    logic [3:0]  nbyte_q,      nbyte_d;
    logic        rnw_q,        rnw_d;
    logic [15:0] whi_q,        whi_d;
    logic [15:0] lo_q,         lo_d;
    logic [31:0] de_r_data_q,  de_r_data_d;
    logic [18:0] sram_addr_q,  sram_addr_d;
    logic [15:0] sram_wdata_q, sram_wdata_d;

    logic half_done;

`ifdef FSR_WAITSTATE_EN
    localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic ctr_load;

    // Reload on every entry into a half, including the LO -> HI step.
    assign ctr_load = ((state_d == LO) || (state_d == HI)) && (state_d != state_q);

    fsr_wait_ctr #(
        .WIDTH (CW)
    ) u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .load_val (CW'(WAIT_STATES)),
        .done     (half_done)
    );
`else
    assign half_done = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        nbyte_d      = nbyte_q;
        rnw_d        = rnw_q;
        whi_d        = whi_q;
        lo_d         = lo_q;
        de_r_data_d  = de_r_data_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (de_req) begin
                    addr_d  = de_addr;
                    nbyte_d = de_nbyte;
                    rnw_d   = de_rnw;
                    whi_d   = de_w_data[31:16];
                    // The SRAM address/data registers load on the accept edge so
                    // they are already stable on the first cycle of the half.
                    if (!in_frame(de_addr)) begin
                        state_d = ACK;
                        if (de_rnw) begin
                            de_r_data_d = '0;
                        end
                    end else if (de_rnw || !(&de_nbyte[1:0])) begin
                        state_d      = LO;
                        sram_addr_d  = {de_addr, HALF_LO};
                        sram_wdata_d = de_w_data[15:0];
                    end else if (!(&de_nbyte[3:2])) begin
                        state_d      = HI;
                        sram_addr_d  = {de_addr, HALF_HI};
                        sram_wdata_d = de_w_data[31:16];
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            LO: begin
                if (half_done) begin
                    lo_d = sram_rdata;
                    if (rnw_q || !(&nbyte_q[3:2])) begin
                        state_d      = HI;
                        sram_addr_d  = {addr_q, HALF_HI};
                        sram_wdata_d = whi_q;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            HI: begin
                if (half_done) begin
                    if (rnw_q) begin
                        de_r_data_d = {sram_rdata, lo_q};
                    end
                    state_d = ACK;
                end
            end
            // The initiator moves its address on the ack edge, so de_req is
            // deliberately not looked at here.
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            nbyte_q      <= '1;
            rnw_q        <= 1'b0;
            whi_q        <= '0;
            lo_q         <= '0;
            de_r_data_q  <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            nbyte_q      <= nbyte_d;
            rnw_q        <= rnw_d;
            whi_q        <= whi_d;
            lo_q         <= lo_d;
            de_r_data_q  <= de_r_data_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    always_comb begin
        sram_be = 2'b00;
        unique case (state_q)
            LO:      sram_be = rnw_q ? 2'b11 : ~nbyte_q[1:0];
            HI:      sram_be = rnw_q ? 2'b11 : ~nbyte_q[3:2];
            default: sram_be = 2'b00;
        endcase
    end

    assign sram_cs    = (state_q == LO) || (state_q == HI);
    assign sram_we    = sram_cs && !rnw_q;
    assign de_ack     = (state_q == ACK);
    assign de_r_data  = de_r_data_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_frame_store_responder.sv
// tb/tb_frame_store_responder.sv - randomized self-checking bench for frame_store_responder

module tb_frame_store_responder;

    localparam int WS_PARAM    = 2;
`ifdef FSR_WAITSTATE_EN
    localparam int WS_EFF      = WS_PARAM;
`else
    localparam int WS_EFF      = 0;
`endif
    localparam int HALF_CYC    = 1 + WS_EFF;
    localparam int FRAME_WORDS_TB = 76800;

    logic        clk;
    logic        rst_n;
    logic        de_req;
    logic        de_ack;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic        de_rnw;
    logic [31:0] de_w_data;
    logic [31:0] de_r_data;
    logic        sram_cs;
    logic        sram_we;
    logic [1:0]  sram_be;
    logic [18:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    frame_store_responder #(
        .WAIT_STATES (WS_PARAM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de_req     (de_req),
        .de_ack     (de_ack),
        .de_addr    (de_addr),
        .de_nbyte   (de_nbyte),
        .de_rnw     (de_rnw),
        .de_w_data  (de_w_data),
        .de_r_data  (de_r_data),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // SRAM device model: halfword storage with a deterministic power-up pattern.
    logic [15:0] sram_mem [int];
    logic        sram_tick = 1'b0;

    function automatic logic [15:0] init_half(input int a);
        return 16'((a * 40503 + 7467) ^ (a >> 3));
    endfunction

    function automatic logic [15:0] sram_peek(input logic [18:0] a);
        if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
        return init_half(int'(a));
    endfunction

    always @(sram_addr, sram_tick, rst_n) sram_rdata = sram_peek(sram_addr);

    always @(posedge clk) begin
        if (sram_cs && sram_we) begin
            logic [15:0] cur;
            cur = sram_peek(sram_addr);
            if (sram_be[0]) cur[7:0]  = sram_wdata[7:0];
            if (sram_be[1]) cur[15:8] = sram_wdata[15:8];
            sram_mem[int'(sram_addr)] = cur;
            sram_tick <= ~sram_tick;
        end
    end

    // Reference model: a word-addressed frame with byte-enable merging.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = '0;

    function automatic logic [31:0] ref_peek(input logic [17:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return {init_half(2 * int'(a) + 1), init_half(2 * int'(a))};
    endfunction

    task automatic ref_write(input logic [17:0] a, input logic [3:0] nb, input logic [31:0] wd);
        logic [31:0] w;
        if (int'(a) < FRAME_WORDS_TB) begin
            w = ref_peek(a);
            for (int i = 0; i < 4; i++) begin
                if (!nb[i]) w[8*i +: 8] = wd[8*i +: 8];
            end
            ref_mem[int'(a)] = w;
        end
    endtask

    task automatic wait_ack(output int cyc);
        cyc = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (de_ack) begin
                cyc = k;
                break;
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_xfer(input logic [17:0] a, input logic [3:0] nb, input logic rnw,
                           input logic [31:0] wd);
        logic [18:0] ex_addr [2];
        logic [1:0]  ex_be   [2];
        logic [15:0] ex_wd   [2];
        int          nh;
        int          cs_cnt;
        int          lat;
        int          idx;
        bit          in_rng;
        logic [31:0] exp_rd;

        nh     = 0;
        cs_cnt = 0;
        lat    = 0;
        in_rng = int'(a) < FRAME_WORDS_TB;
        if (in_rng) begin
            if (rnw || nb[1:0] != 2'b11) begin
                ex_addr[nh] = {a, 1'b0};
                ex_be[nh]   = rnw ? 2'b11 : ~nb[1:0];
                ex_wd[nh]   = wd[15:0];
                nh++;
            end
            if (rnw || nb[3:2] != 2'b11) begin
                ex_addr[nh] = {a, 1'b1};
                ex_be[nh]   = rnw ? 2'b11 : ~nb[3:2];
                ex_wd[nh]   = wd[31:16];
                nh++;
            end
        end
        exp_rd = in_rng ? ref_peek(a) : 32'h0;

        de_req    = 1'b1;
        de_addr   = a;
        de_nbyte  = nb;
        de_rnw    = rnw;
        de_w_data = wd;
        @(posedge clk);
        #1;
        // Scramble the request lines; the latched copy must be what is used.
        de_req    = 1'b0;
        de_addr   = 18'($urandom);
        de_nbyte  = 4'($urandom);
        de_rnw    = 1'($urandom);
        de_w_data = $urandom;

        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (de_ack) begin
                lat = k + 1;
                break;
            end
            if (sram_cs) begin
                idx = cs_cnt / HALF_CYC;
                if (idx < nh) begin
                    check_eq("sram_addr", 32'(sram_addr), 32'(ex_addr[idx]));
                    check_eq("sram_be", 32'(sram_be), 32'(ex_be[idx]));
                    check_eq("sram_we", 32'(sram_we), 32'(!rnw));
                    if (!rnw) check_eq("sram_wdata", 32'(sram_wdata), 32'(ex_wd[idx]));
                end
                cs_cnt++;
            end
        end

        check_eq("ack_seen", 32'(lat != 0), 32'd1);
        check_eq("latency", 32'(lat), 32'(nh * HALF_CYC + 1));
        check_eq("cs_cycles", 32'(cs_cnt), 32'(nh * HALF_CYC));
        if (rnw) begin
            last_rd = exp_rd;
        end else begin
            ref_write(a, nb, wd);
        end
        check_eq("r_data_at_ack", de_r_data, last_rd);

        @(negedge clk);
        check_eq("ack_one_cycle", 32'(de_ack), 32'd0);
        check_eq("r_data_hold", de_r_data, last_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          acks;
        logic [31:0] wd_a, wd_b, wd_c, wd_d;

        rst_n     = 1'b1;
        de_req    = 1'b0;
        de_addr   = '0;
        de_nbyte  = '1;
        de_rnw    = 1'b0;
        de_w_data = '0;
        #1 rst_n  = 1'b0;
        #2;
        check_eq("rst_ack", 32'(de_ack), 32'd0);
        check_eq("rst_cs", 32'(sram_cs), 32'd0);
        check_eq("rst_we", 32'(sram_we), 32'd0);
        check_eq("rst_be", 32'(sram_be), 32'd0);
        check_eq("rst_rdata", de_r_data, 32'd0);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_wdata", 32'(sram_wdata), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single low-half write, single high-half write.
        do_xfer(18'h00010, 4'b1110, 1'b0, 32'h000000A5);
        do_xfer(18'h00011, 4'b0111, 1'b0, 32'h5A000000);
        // Known word, then read it back through both halves.
        do_xfer(18'd5, 4'b0000, 1'b0, 32'hABCD1234);
        do_xfer(18'd5, 4'b1010, 1'b1, 32'h0);
        check_eq("read_word5", de_r_data, 32'hABCD1234);
        // Fully masked write: no access.
        do_xfer(18'd6, 4'b1111, 1'b0, 32'hDEADBEEF);
        // Frame boundary.
        do_xfer(18'd76799, 4'b0000, 1'b0, 32'h13579BDF);
        do_xfer(18'd76799, 4'b0000, 1'b1, 32'h0);
        check_eq("read_last_word", de_r_data, 32'h13579BDF);
        do_xfer(18'd76800, 4'b0000, 1'b0, 32'hFFFFFFFF);
        do_xfer(18'd76800, 4'b0000, 1'b1, 32'h0);
        check_eq("read_out_of_frame", de_r_data, 32'h0);

        // Back-to-back writes with reset landing in the third.
        wd_a = $urandom; wd_b = $urandom; wd_c = $urandom; wd_d = $urandom;
        de_req = 1'b1; de_rnw = 1'b0; de_nbyte = 4'b0000;
        de_addr = 18'd100; de_w_data = wd_a;
        wait_ack(cyc);
        check_eq("b2b_ack_a", 32'(cyc >= 0), 32'd1);
        ref_write(18'd100, 4'b0000, wd_a);
        de_addr = 18'd101; de_w_data = wd_b;
        wait_ack(cyc);
        check_eq("b2b_ack_b", 32'(cyc >= 0), 32'd1);
        ref_write(18'd101, 4'b0000, wd_b);
        de_addr = 18'd102; de_w_data = wd_c;
        cyc = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (sram_cs) begin
                cyc = k;
                break;
            end
        end
        check_eq("b2b_c_started", 32'(cyc >= 0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_cs", 32'(sram_cs), 32'd0);
        check_eq("midrst_we", 32'(sram_we), 32'd0);
        check_eq("midrst_be", 32'(sram_be), 32'd0);
        check_eq("midrst_ack", 32'(de_ack), 32'd0);
        check_eq("midrst_addr", 32'(sram_addr), 32'd0);
        last_rd = 32'h0;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (de_ack) acks++;
        end
        check_eq("no_ack_for_c", 32'(acks), 32'd0);
        de_addr = 18'd103; de_w_data = wd_d;
        rst_n = 1'b1;
        wait_ack(cyc);
        check_eq("b2b_ack_d", 32'(cyc >= 0), 32'd1);
        check_eq("b2b_latency_d", 32'(cyc + 1), 32'(2 * HALF_CYC + 1));
        ref_write(18'd103, 4'b0000, wd_d);
        de_req = 1'b0;
        @(negedge clk);
        for (int i = 100; i < 104; i++) begin
            do_xfer(18'(i), 4'($urandom), 1'b1, $urandom);
        end

        // Randomized traffic over a small window plus the frame edge.
        for (int n = 0; n < 60; n++) begin
            logic [17:0] a;
            if ($urandom_range(0, 7) == 0) a = 18'(76795 + $urandom_range(0, 10));
            else                           a = 18'($urandom_range(0, 15));
            do_xfer(a, 4'($urandom), 1'($urandom), $urandom);
        end
        for (int i = 0; i < 16; i++) begin
            do_xfer(18'(i), 4'b1111, 1'b1, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_store_responder.md
FRAME_STORE_RESPONDER -- requirements
Module: frame_store_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, extra cycles held per SRAM halfword access (used only with FSR_WAITSTATE_EN).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-003 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: de_req  in  1  drawing-engine request, level.
REQ-005 SHALL have: de_ack  out  1  one-cycle completion pulse.
REQ-006 SHALL have: de_addr  in  18  32-bit word address.
REQ-007 SHALL have: de_nbyte  in  4  active-low byte enables; bit i maps to byte i.
REQ-008 SHALL have: de_rnw  in  1  1 = read, 0 = write.
REQ-009 SHALL have: de_w_data  in  32  write data.
REQ-010 SHALL have: de_r_data  out  32  read data, valid while de_ack = 1.
REQ-011 SHALL have: sram_cs  out  1;  sram_we  out  1;  sram_be  out  2 (active-high byte lanes).
REQ-012 SHALL have: sram_addr  out  19  halfword address {de_addr, half};  sram_wdata  out  16;  sram_rdata  in  16.

Function
REQ-013 SHALL implement states IDLE, LO, HI, ACK.
REQ-014 In IDLE with de_req = 1, SHALL latch de_addr, de_nbyte, de_rnw and de_w_data at that edge.
REQ-015 Write access: SHALL access the low half only if any of nbyte[1:0] = 0, and the high half only if any of nbyte[3:2] = 0.
REQ-016 Write access: sram_be SHALL equal the inverted nbyte pair, and fully masked halves SHALL be skipped.
REQ-017 Read access: SHALL always access LO then HI with sram_be = 2'b11, ignoring de_nbyte.
REQ-018 Read access: SHALL capture sram_rdata on the last cycle of each half and assemble {hi, lo}.
REQ-019 Each access cycle SHALL assert sram_cs = 1 and sram_we = !rnw.
REQ-020 Each half SHALL last 1 cycle, or 1 + WAIT_STATES cycles with FSR_WAITSTATE_EN.
REQ-021 sram_addr, sram_be and sram_wdata SHALL be stable for the whole half.
REQ-022 Every accepted request SHALL produce exactly one ACK state.
REQ-023 In ACK, de_ack SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-024 A new request SHALL NOT be sampled in the ACK cycle, since the initiator updates its address on the ack edge.
REQ-025 With de_req still high in IDLE, SHALL accept the next request (back-to-back at one IDLE cycle per transfer).
REQ-026 A write with nbyte = 4'b1111 SHALL perform no SRAM access and SHALL go IDLE -> ACK.
REQ-027 For a word address >= FRAME_WORDS (76800), SHALL perform no SRAM access, SHALL return de_r_data = 0, and SHALL still acknowledge.
REQ-028 de_r_data SHALL hold its last value outside ACK.
REQ-029 Changes on de_* inputs after acceptance SHALL have no effect until the next IDLE.
REQ-030 Latency, accept edge to de_ack rise, SHALL be (number of halves accessed) x (1 + waits) + 1 cycles.

Reset
REQ-031 rst_n = 0 SHALL immediately force the outputs: state IDLE, de_ack = 0, sram_cs = 0, sram_we = 0, sram_be = 0.
REQ-032 rst_n = 0 SHALL immediately force the registers: de_r_data = 0, sram_addr = 0, sram_wdata = 0, wait counter = 0.
REQ-033 Reset mid-transfer SHALL abort without acknowledging; the in-flight request SHALL be lost.
REQ-034 After rst_n rises, the first edge with de_req = 1 SHALL be treated as a fresh request.

Configuration
REQ-035 Macro FSR_WAITSTATE_EN defined: each half SHALL hold for 1 + WAIT_STATES cycles via a down-counter.
REQ-036 FSR_WAITSTATE_EN undefined: WAIT_STATES SHALL be ignored, no counter logic SHALL be present, and every half SHALL take 1 cycle.

Structure
REQ-037 Package frame_store_pkg SHALL hold: the state enum, FRAME_WORDS = 76800, SCREEN_W = 640, and the halfword select constants.
REQ-038 Sub-module fsr_wait_ctr (load, count-down, done) SHALL be instantiated only under FSR_WAITSTATE_EN.

Verification
REQ-039 Write addr = 0x00010, nbyte = 1110, w_data = 0x000000A5 -> one cycle with sram_addr = 0x00020, be = 01, wdata = 0x00A5, we = 1; de_ack rises 2 cycles after accept.
REQ-040 Write nbyte = 0111, w_data = 0x5A000000 -> only the HI access, sram_addr odd, be = 10, wdata = 0x5A00.
REQ-041 Read addr = 5 with sram_rdata returning 0x1234 (LO) then 0xABCD (HI) -> de_r_data = 0xABCD1234 with de_ack; latency 3.
REQ-042 With WAIT_STATES = 2 and the macro on, a read -> each half held 3 cycles; latency 7.
REQ-043 Write addr = 76800 -> sram_cs never asserted, de_ack after 1 cycle; a read at the same address returns 0.
REQ-044 De_req held high over 4 consecutive writes, with rst_n pulsed low during the 3rd -> first 2 acked, strobes drop asynchronously, no ack for the 3rd, and the 4th completes normally after reset.
